// File: rtl/divmod_pkg.sv
// Shared types and the restoring-division step for the divmod pipeline.
// Operand, remainder and tag widths are fixed here; every module of the
// pipeline sizes its datapath from these constants.
package divmod_pkg;

  localparam int DIVIDEND_W         = 16;
  localparam int DIVISOR_W          = 8;
  localparam int TAG_W              = 5;
  localparam int DEF_BITS_PER_STAGE = 1;
  localparam int NUM_STAGES         = DIVIDEND_W / DEF_BITS_PER_STAGE;

  // Everything one operand pair carries down the pipe.
  // rem is one bit wider than the divisor so the shifted partial remainder
  // (up to 2*divisor-1) never overflows before the compare.
  typedef struct packed {
    logic                  valid;
    logic [DIVISOR_W:0]    rem;
    logic [DIVIDEND_W-1:0] dividend_shift;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  neg_q;
    logic                  neg_r;
    logic                  dbz;
    logic                  ovf;
    logic [TAG_W-1:0]      tag;
  } stage_t;

  // One restoring step, MSB first: shift the next dividend bit into the
  // partial remainder, subtract the divisor when it fits, record the bit.
  // With divisor 0 every step subtracts nothing, so the quotient fills with
  // ones and the remainder ends up holding the low dividend bits.
  function automatic stage_t f_div_step(input stage_t s);
    stage_t             n;
    logic [DIVISOR_W:0] trial;
    n     = s;
    trial = {s.rem[DIVISOR_W-1:0], s.dividend_shift[DIVIDEND_W-1]};
    n.dividend_shift = {s.dividend_shift[DIVIDEND_W-2:0], 1'b0};
    if (trial >= {1'b0, s.divisor}) begin
      n.rem      = trial - {1'b0, s.divisor};
      n.quotient = {s.quotient[DIVIDEND_W-2:0], 1'b1};
    end else begin
      n.rem      = trial;
      n.quotient = {s.quotient[DIVIDEND_W-2:0], 1'b0};
    end
    return n;
  endfunction

endpackage

// File: rtl/divmod_stage.sv
// One pipeline register of the divider: resolves BITS_PER_STAGE quotient
// bits on the incoming operand and holds the result with its valid bit.
module divmod_stage
  import divmod_pkg::*;
#(
  parameter int BITS_PER_STAGE = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  stage_t prev,        // upstream content (valid bit included)
  input  logic   next_ready,  // downstream takes this register's content now
  output logic   ready,       // this register loads at the next edge
  output stage_t cur
);

  stage_t stepped;

  // Apply this stage's share of restoring steps to the upstream operand.
  always_comb begin
    stepped = prev;
    for (int i = 0; i < BITS_PER_STAGE; i++) begin
      stepped = f_div_step(stepped);
    end
  end

  // An empty register always loads, so bubbles collapse even while the
  // output is stalled; a full one loads only when its content moves on.
  assign ready = ~cur.valid | next_ready;

  // Stage register; an upstream bubble loads as valid=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= '0;
    end else if (ready) begin
      cur <= stepped;
    end
  end

endmodule

// File: rtl/divmod_pipe.sv
// Fully pipelined quotient/remainder unit with elastic valid/ready flow.
// Handshake: on either side a transfer happens in a cycle where valid and
// ready are both high; valid and payload stay stable until then, and
// in_ready may ripple combinationally from out_ready.
// Signed ops divide magnitudes; an extra register (SIGNED_EN=1) restores
// the signs. Divide-by-zero bypasses the sign handling entirely.
module divmod_pipe
  import divmod_pkg::*;
#(
  parameter int BITS_PER_STAGE = DIVIDEND_W / NUM_STAGES,
  parameter int SIGNED_EN      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] in_dividend,
  input  logic [DIVISOR_W-1:0]  in_divisor,
  input  logic                  in_signed,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] out_quotient,
  output logic [DIVISOR_W-1:0]  out_remainder,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_div_by_zero,
  output logic                  out_overflow
);

  localparam int STAGES = DIVIDEND_W / BITS_PER_STAGE;
  localparam logic [DIVIDEND_W-1:0] DVD_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};

  logic   sign_mode;
  logic   dvd_neg;
  logic   dvs_neg;
  logic   dbz;
  logic   ovf;
  stage_t head;
  stage_t last;
  stage_t st  [STAGES];
  logic   rdy [STAGES+1];

  // Input conditioning: magnitudes for signed ops (|MIN| fits unsigned),
  // raw operands for divide-by-zero so the remainder is the raw low bits.
  always_comb begin
    sign_mode = (SIGNED_EN != 0) && in_signed;
    dbz       = (in_divisor == '0);
    dvd_neg   = sign_mode & in_dividend[DIVIDEND_W-1];
    dvs_neg   = sign_mode & in_divisor[DIVISOR_W-1];
    ovf       = sign_mode & (in_dividend == DVD_MIN) & (in_divisor == '1);
    head                = '0;
    head.valid          = in_valid;
    head.dividend_shift = (dvd_neg & ~dbz) ? -in_dividend : in_dividend;
    head.divisor        = dvs_neg ? -in_divisor : in_divisor;
    head.neg_q          = ~dbz & (dvd_neg ^ dvs_neg);
    head.neg_r          = ~dbz & dvd_neg;
    head.dbz            = dbz;
    head.ovf            = ovf;
    head.tag            = in_tag;
  end

  assign in_ready = rdy[0];
  assign last     = st[STAGES-1];

  // Chain of division stages, each fed by its predecessor.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    stage_t prev_s;
    if (s == 0) begin : g_head
      assign prev_s = head;
    end else begin : g_link
      assign prev_s = st[s-1];
    end
    divmod_stage #(.BITS_PER_STAGE(BITS_PER_STAGE)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .prev       (prev_s),
      .next_ready (rdy[s+1]),
      .ready      (rdy[s]),
      .cur        (st[s])
    );
  end

  if (SIGNED_EN != 0) begin : g_fix
    logic                  fx_valid;
    logic [DIVIDEND_W-1:0] fx_q;
    logic [DIVISOR_W-1:0]  fx_r;
    logic [TAG_W-1:0]      fx_tag;
    logic                  fx_dbz;
    logic                  fx_ovf;

    assign rdy[STAGES] = ~fx_valid | out_ready;

    // Sign fix-up register: quotient truncates toward zero, remainder
    // follows the dividend sign. MIN/-1 needs no special case: the
    // magnitude quotient is already the MIN bit pattern.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        fx_valid <= 1'b0;
        fx_q     <= '0;
        fx_r     <= '0;
        fx_tag   <= '0;
        fx_dbz   <= 1'b0;
        fx_ovf   <= 1'b0;
      end else if (rdy[STAGES]) begin
        fx_valid <= last.valid;
        fx_q     <= last.neg_q ? -last.quotient : last.quotient;
        fx_r     <= last.neg_r ? -last.rem[DIVISOR_W-1:0] : last.rem[DIVISOR_W-1:0];
        fx_tag   <= last.tag;
        fx_dbz   <= last.dbz;
        fx_ovf   <= last.ovf;
      end
    end

    assign out_valid       = fx_valid;
    assign out_quotient    = fx_q;
    assign out_remainder   = fx_r;
    assign out_tag         = fx_tag;
    assign out_div_by_zero = fx_dbz;
    assign out_overflow    = fx_ovf;
  end else begin : g_nofix
    assign rdy[STAGES]     = out_ready;
    assign out_valid       = last.valid;
    assign out_quotient    = last.quotient;
    assign out_remainder   = last.rem[DIVISOR_W-1:0];
    assign out_tag         = last.tag;
    assign out_div_by_zero = last.dbz;
    assign out_overflow    = last.ovf;
  end

  // Fields that are exhausted by the time an operand reaches the end.
  logic unused_last;
  assign unused_last = ^{last.dividend_shift, last.rem[DIVISOR_W], last.divisor,
                         last.neg_q, last.neg_r};

endmodule

// File: tb/tb_divmod_pipe.sv
// Bench for divmod_pipe: three configurations driven from one shared
// operand bus (unsigned BPS=1, signed BPS=1, unsigned BPS=2), each with its
// own accept/drain scoreboard against an arithmetic reference model.
module tb_divmod_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_dividend;
  logic [7:0]  in_divisor;
  logic        in_signed;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready        [3];
  logic        out_valid       [3];
  logic [15:0] out_quotient    [3];
  logic [7:0]  out_remainder   [3];
  logic [4:0]  out_tag         [3];
  logic        out_div_by_zero [3];
  logic        out_overflow    [3];

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- DUTs ----------------
  for (genvar g = 0; g < 3; g++) begin : g_dut
    divmod_pipe #(
      .BITS_PER_STAGE ((g == 2) ? 2 : 1),
      .SIGNED_EN      ((g == 1) ? 1 : 0)
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready[g]),
      .in_dividend     (in_dividend),
      .in_divisor      (in_divisor),
      .in_signed       (in_signed),
      .in_tag          (in_tag),
      .out_valid       (out_valid[g]),
      .out_ready       (out_ready),
      .out_quotient    (out_quotient[g]),
      .out_remainder   (out_remainder[g]),
      .out_tag         (out_tag[g]),
      .out_div_by_zero (out_div_by_zero[g]),
      .out_overflow    (out_overflow[g])
    );
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    case (i)
      0:       return 16;
      1:       return 17;
      default: return 8;
    endcase
  endfunction

  // Reference: plain integer division; SV / and % truncate toward zero and
  // give the remainder the dividend's sign, which is the required rule.
  function automatic logic [25:0] ref_model(input logic [15:0] dvd, input logic [7:0] dvs,
                                            input logic sgn, input bit se);
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
    int          a;
    int          b;
    dz = 1'b0;
    ov = 1'b0;
    if (dvs == 8'd0) begin
      q  = 16'hFFFF;
      r  = dvd[7:0];
      dz = 1'b1;
    end else if (sgn && se) begin
      a = $signed(dvd);
      b = $signed(dvs);
      if (a == -32768 && b == -1) begin
        q  = 16'h8000;
        r  = 8'h00;
        ov = 1'b1;
      end else begin
        q = 16'(a / b);
        r = 8'(a % b);
      end
    end else begin
      q = dvd / {8'd0, dvs};
      r = 8'(dvd % {8'd0, dvs});
    end
    return {q, r, dz, ov};
  endfunction

  // ---------------- scoreboards (one per DUT) ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sb
    localparam int L  = (g == 0) ? 16 : (g == 1) ? 17 : 8;
    localparam bit SE = (g == 1);
    logic [30:0] exp_q[$];
    logic [30:0] cur_v;
    logic [30:0] exp_v;
    logic [30:0] held_v;
    logic        held = 1'b0;

    always @(negedge clk) begin
      if (rst) begin
        exp_q.delete();
        held = 1'b0;
      end else begin
        cur_v = {out_tag[g], out_quotient[g], out_remainder[g],
                 out_div_by_zero[g], out_overflow[g]};
        // in_ready may drop only with every register full and output stalled
        check($sformatf("in_ready[%0d]", g), 32'(in_ready[g]),
              32'(!(exp_q.size() == L && !out_ready)));
        if (held) begin
          check($sformatf("hold_valid[%0d]", g), 32'(out_valid[g]), 32'd1);
          check($sformatf("hold_data[%0d]", g), 32'(cur_v), 32'(held_v));
        end
        if (out_valid[g] && out_ready) begin
          if (exp_q.size() == 0) begin
            check($sformatf("spurious[%0d]", g), 32'(out_valid[g]), 32'd0);
          end else begin
            exp_v = exp_q.pop_front();
            check($sformatf("result[%0d]", g), 32'(cur_v), 32'(exp_v));
          end
        end
        if (in_valid && in_ready[g]) begin
          exp_q.push_back({in_tag, ref_model(in_dividend, in_divisor, in_signed, SE)});
        end
        held   = out_valid[g] && !out_ready;
        held_v = cur_v;
      end
    end
  end

  // ---------------- driver tasks (all start and end at posedge+1) ----------------
  task automatic rand_ops();
    in_dividend = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
    case ($urandom_range(0, 9))
      0:       in_divisor = 8'h00;
      1:       in_divisor = 8'hFF;
      default: in_divisor = 8'($urandom);
    endcase
    in_signed = 1'($urandom_range(0, 1));
    in_tag    = 5'($urandom);
  endtask

  task automatic directed(input string name, input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic sgn, input logic [4:0] tg, input logic [15:0] eq,
                          input logic [7:0] er, input logic edz, input logic eov,
                          input logic [2:0] mask);
    int lat  [3];
    bit seen [3];
    for (int i = 0; i < 3; i++) begin
      lat[i]  = 0;
      seen[i] = 1'b0;
    end
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_dividend = dvd;
    in_divisor  = dvs;
    in_signed   = sgn;
    in_tag      = tg;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!seen[i] && out_valid[i]) begin
          seen[i] = 1'b1;
          lat[i]  = c;
          if (mask[i]) begin
            check($sformatf("%s_q[%0d]", name, i), 32'(out_quotient[i]), 32'(eq));
            check($sformatf("%s_r[%0d]", name, i), 32'(out_remainder[i]), 32'(er));
            check($sformatf("%s_tag[%0d]", name, i), 32'(out_tag[i]), 32'(tg));
            check($sformatf("%s_dbz[%0d]", name, i), 32'(out_div_by_zero[i]), 32'(edz));
            check($sformatf("%s_ovf[%0d]", name, i), 32'(out_overflow[i]), 32'(eov));
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_lat[%0d]", name, i), 32'(lat[i]), 32'(lat_of(i)));
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic stream();
    int cyc  = 0;
    int acc0 = 0;
    while (acc0 < 40 && cyc < 2000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      rand_ops();
      @(negedge clk);
      if (in_valid && in_ready[0]) acc0++;
      @(posedge clk); #1;
      cyc++;
    end
    check("stream_ops", 32'(acc0), 32'd40);
    in_valid = 1'b0;
  endtask

  task automatic full_pipe();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (20) begin
      rand_ops();
      @(posedge clk); #1;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("full_stall_rdy[%0d]", i), 32'(in_ready[i]), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    rand_ops();
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("full_xfer_rdy[%0d]", i), 32'(in_ready[i]), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("full_after_rdy[%0d]", i), 32'(in_ready[i]), 32'd0);
      check($sformatf("full_after_vld[%0d]", i), 32'(out_valid[i]), 32'd1);
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_mid();
    int seen_out = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (6) begin
      rand_ops();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("pre_rst_vld[%0d]", i), 32'(out_valid[i]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("arst_vld[%0d]", i), 32'(out_valid[i]), 32'd0);
      check($sformatf("arst_data[%0d]", i),
            32'({out_quotient[i], out_remainder[i], out_tag[i],
                 out_div_by_zero[i], out_overflow[i]}), 32'd0);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (40) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (out_valid[i]) seen_out++;
    end
    check("post_rst_quiet", 32'(seen_out), 32'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    in_signed   = 1'b0;
    in_tag      = '0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_vld[%0d]", i), 32'(out_valid[i]), 32'd0);
      check($sformatf("rst_q[%0d]", i), 32'(out_quotient[i]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) check($sformatf("rel_rdy[%0d]", i), 32'(in_ready[i]), 32'd1);

    directed("u1000_7",  16'd1000,  8'd7,   1'b0, 5'd3, 16'd142,   8'd6,   1'b0, 1'b0, 3'b111);
    directed("dbz1234",  16'd1234,  8'd0,   1'b0, 5'd4, 16'hFFFF,  8'hD2,  1'b1, 1'b0, 3'b111);
    directed("s_m7_2",   16'hFFF9,  8'd2,   1'b1, 5'd5, 16'hFFFD,  8'hFF,  1'b0, 1'b0, 3'b010);
    directed("s_7_m2",   16'd7,     8'hFE,  1'b1, 5'd6, 16'hFFFD,  8'h01,  1'b0, 1'b0, 3'b010);
    directed("s_min_m1", 16'h8000,  8'hFF,  1'b1, 5'd7, 16'h8000,  8'h00,  1'b0, 1'b1, 3'b010);
    directed("s_dbz",    16'hFF85,  8'd0,   1'b1, 5'd8, 16'hFFFF,  8'h85,  1'b1, 1'b0, 3'b111);

    stream();
    drain();
    full_pipe();
    drain();
    reset_mid();
    directed("u100_9",   16'd100,   8'd9,   1'b0, 5'd9, 16'd11,    8'd1,   1'b0, 1'b0, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
